// File: rtl/irq_pkg.sv
// Shared constants, FSM state and priority helper
// for the interrupt pending/arbitration stage.
package irq_pkg;

  localparam int N_IRQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_e;

  // Highest-numbered set bit wins; all-zero input yields 0.
  function automatic logic [IDX_W-1:0] prio_sel(
    input logic [N_IRQ-1:0] v
  );
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (v[i]) r = i[IDX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational MSB-first selector with an
// any-bit-set flag.
module irq_prio_sel
  import irq_pkg::*;
(
  input  logic [N_IRQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = prio_sel(vec);
    any = |vec;
  end

endmodule

// File: rtl/irq_pend_arb.sv
// Edge-captured sticky pending bits with masked
// priority selection and a valid/ack presentation.
module irq_pend_arb #(
  parameter int N     = irq_pkg::N_IRQ,
  parameter int IDX_W = irq_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask_in,
  input  logic [N-1:0]     clr_in,
  input  logic             irq_ack,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  output logic [N-1:0]     pending_out,
  output logic [N-1:0]     overrun_out
);

  import irq_pkg::irq_state_e;
  import irq_pkg::IDLE;
  import irq_pkg::PRESENT;

  logic [N-1:0]     req_q;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     ovr_q, ovr_d;
  logic [N-1:0]     rise;
  logic [N-1:0]     elig;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] sel;
  logic             sel_any;
  logic             ack_fire;
  irq_state_e       state_q, state_d;

  assign rise     = req_in & ~req_q;
  assign ack_fire = irq_ack & valid_q;
  assign elig     = pend_q & mask_in;

  irq_prio_sel u_sel (
    .vec (elig),
    .idx (sel),
    .any (sel_any)
  );

  // A new event always beats either kind of clear.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int i = 0; i < N; i++) begin
      if (rise[i]) begin
        pend_d[i] = 1'b1;
      end else if (clr_in[i] ||
                   (ack_fire &&
                    idx_q == i[IDX_W-1:0])) begin
        pend_d[i] = 1'b0;
      end
      if (rise[i] && pend_q[i]) begin
        ovr_d[i] = 1'b1;
      end else if (clr_in[i]) begin
        ovr_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (sel_any) begin
          idx_d   = sel;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        valid_d = 1'b1;
        if (ack_fire) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      state_q <= IDLE;
    end else begin
      req_q   <= req_in;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  assign irq_valid   = valid_q;
  assign irq_idx     = idx_q;
  assign pending_out = pend_q;
  assign overrun_out = ovr_q;

endmodule

// File: tb/tb_irq_pend_arb.sv
// Randomized and directed checks of irq_pend_arb
// against a cycle-level behavioural model.
module tb_irq_pend_arb;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask_in;
  logic [7:0] clr_in;
  logic       irq_ack;
  logic       irq_valid;
  logic [2:0] irq_idx;
  logic [7:0] pending_out;
  logic [7:0] overrun_out;

  int n_chk;
  int n_fail;

  // behavioural model state
  bit [7:0] m_req;
  bit [7:0] m_pend;
  bit [7:0] m_ovr;
  bit       m_valid;
  int       m_idx;

  irq_pend_arb dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .mask_in     (mask_in),
    .clr_in      (clr_in),
    .irq_ack     (irq_ack),
    .irq_valid   (irq_valid),
    .irq_idx     (irq_idx),
    .pending_out (pending_out),
    .overrun_out (overrun_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int highest(input bit [7:0] v);
    int h;
    h = -1;
    for (int i = 7; i >= 0; i--) begin
      if (v[i] && h < 0) h = i;
    end
    return h;
  endfunction

  // Advance the model by one clock using this
  // cycle's inputs and the pre-edge state.
  task automatic model_edge(
    input bit [7:0] r,
    input bit [7:0] m,
    input bit [7:0] c,
    input bit       a,
    input bit       rs
  );
    bit [7:0] np, no, rise;
    bit       fire;
    int       h;
    if (rs) begin
      m_req   = '0;
      m_pend  = '0;
      m_ovr   = '0;
      m_valid = 0;
      m_idx   = 0;
      return;
    end
    rise = r & ~m_req;
    fire = a && m_valid;
    np = m_pend;
    no = m_ovr;
    for (int i = 0; i < 8; i++) begin
      if (rise[i]) np[i] = 1;
      else if (c[i] || (fire && i == m_idx)) np[i] = 0;
      if (rise[i] && m_pend[i]) no[i] = 1;
      else if (c[i]) no[i] = 0;
    end
    if (!m_valid) begin
      h = highest(m_pend & m);
      if (h >= 0) begin
        m_valid = 1;
        m_idx   = h;
      end
    end else if (fire) begin
      m_valid = 0;
    end
    m_pend = np;
    m_ovr  = no;
    m_req  = r;
  endtask

  task automatic step(
    input logic [7:0] r,
    input logic [7:0] m,
    input logic [7:0] c,
    input logic       a,
    input logic       rs
  );
    @(negedge clk);
    req_in  = r;
    mask_in = m;
    clr_in  = c;
    irq_ack = a;
    rst     = rs;
    model_edge(r, m, c, a, rs);
    @(posedge clk);
    #1;
    chk("valid", 32'(irq_valid), 32'(m_valid));
    chk("idx", 32'(irq_idx), 32'(m_idx));
    chk("pending", 32'(pending_out), 32'(m_pend));
    chk("overrun", 32'(overrun_out), 32'(m_ovr));
  endtask

  logic [7:0] rr, rm, rc;
  logic       ra, rrs;

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    req_in  = '0;
    mask_in = '0;
    clr_in  = '0;
    irq_ack = 1'b0;

    step(8'h00, 8'hFF, 8'h00, 0, 1);
    step(8'h00, 8'hFF, 8'h00, 0, 1);
    chk("rst_valid", 32'(irq_valid), 0);
    chk("rst_pend", 32'(pending_out), 0);

    // single request on bit 2
    step(8'h04, 8'hFF, 8'h00, 0, 0);
    chk("single_pend", 32'(pending_out), 32'h04);
    step(8'h00, 8'hFF, 8'h00, 0, 0);
    chk("single_valid", 32'(irq_valid), 1);
    chk("single_idx", 32'(irq_idx), 2);
    step(8'h00, 8'hFF, 8'h00, 1, 0);
    chk("single_ack_pend", 32'(pending_out), 0);
    chk("single_ack_valid", 32'(irq_valid), 0);

    // simultaneous 7 and 6
    step(8'hC0, 8'hFF, 8'h00, 0, 0);
    step(8'h00, 8'hFF, 8'h00, 0, 0);
    chk("two_first", 32'(irq_idx), 7);
    step(8'h00, 8'hFF, 8'h00, 1, 0);
    chk("two_gap", 32'(irq_valid), 0);
    step(8'h00, 8'hFF, 8'h00, 0, 0);
    chk("two_second_v", 32'(irq_valid), 1);
    chk("two_second", 32'(irq_idx), 6);
    step(8'h00, 8'hFF, 8'h00, 1, 0);
    chk("two_done", 32'(pending_out), 0);

    // masked bit 7 waits for unmask
    step(8'h81, 8'h7F, 8'h00, 0, 0);
    step(8'h00, 8'h7F, 8'h00, 0, 0);
    chk("mask_idx0", 32'(irq_idx), 0);
    step(8'h00, 8'h7F, 8'h00, 1, 0);
    chk("mask_keep", 32'(pending_out), 32'h80);
    step(8'h00, 8'hFF, 8'h00, 0, 0);
    chk("unmask_idx7", 32'(irq_idx), 7);
    step(8'h00, 8'hFF, 8'h00, 1, 0);

    // overrun on bit 3, then software clear
    step(8'h08, 8'h00, 8'h00, 0, 0);
    step(8'h00, 8'h00, 8'h00, 0, 0);
    step(8'h08, 8'h00, 8'h00, 0, 0);
    chk("ovr_set", 32'(overrun_out), 32'h08);
    step(8'h08, 8'h00, 8'h08, 0, 0);
    chk("ovr_clr", 32'(overrun_out), 0);
    chk("ovr_pclr", 32'(pending_out), 0);
    step(8'h00, 8'h00, 8'h00, 0, 0);

    // new event on bit 5 in the ack cycle
    step(8'h20, 8'hFF, 8'h00, 0, 0);
    step(8'h00, 8'hFF, 8'h00, 0, 0);
    step(8'h20, 8'hFF, 8'h00, 1, 0);
    chk("race_pend", 32'(pending_out), 32'h20);
    step(8'h00, 8'hFF, 8'h00, 0, 0);
    chk("race_rev", 32'(irq_valid), 1);
    chk("race_idx", 32'(irq_idx), 5);
    step(8'h00, 8'hFF, 8'h00, 1, 0);

    // reset while presenting idx 4
    step(8'h10, 8'hFF, 8'h00, 0, 0);
    step(8'h00, 8'hFF, 8'h00, 0, 0);
    chk("pre_rst_idx", 32'(irq_idx), 4);
    step(8'h00, 8'hFF, 8'h00, 0, 1);
    chk("rst_p_valid", 32'(irq_valid), 0);
    chk("rst_p_idx", 32'(irq_idx), 0);

    // random traffic
    rr = '0;
    for (int k = 0; k < 3000; k++) begin
      rr  = rr ^ 8'($urandom & $urandom & $urandom);
      rm  = ($urandom_range(0, 3) == 0) ?
            8'($urandom) : 8'hFF;
      rc  = ($urandom_range(0, 15) == 0) ?
            8'($urandom & $urandom) : 8'h00;
      ra  = 1'($urandom_range(0, 1));
      rrs = ($urandom_range(0, 199) == 0);
      step(rr, rm, rc, ra, rrs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
